pc8001_ps2_keymatrix: RTL
=========================

Name: pc8001_ps2_keymatrix

Overview:
- Converts the hps_io ps2_key event bus into the PC-8001 10-row × 8-column keyboard matrix that the CPU scans through I/O ports 00h–09h.
- Sits directly upstream of pc8001m, replacing its unused ps2_clk/ps2_data path.
- Holds per-key state, latches the KANA lock, and synthesises the PC-8001 cursor-left/down shift combinations.
- Presents an active-low registered row read to the CPU port decode.

Parameters:
KANA_CODE  9'h013  {ext,scancode} that toggles the KANA lock (JP Katakana key)
STOP_CODE  9'h001  {ext,scancode} mapped to STOP (F9)

Ports:
clk_sys    in   1   system clock, all logic on rising edge
reset      in   1   synchronous, active-high
ps2_key    in   11  [10] toggle per event, [9] 1=press 0=release, [8] extended (E0), [7:0] scancode
row_sel    in   4   matrix row address from CPU port decode (port & 0Fh)
row_data   out  8   selected row, active-low (0 = key down); bit n = column n
kana_lock  out  1   KANA lock state (LED / row8 bit5)
key_any    out  1   1 when any held bit or kana_lock is set

Behaviour:
- Event detect: tog_q <= ps2_key[10] every cycle. An event exists in cycle N when ps2_key[10] != tog_q. Key {ext,code} = ps2_key[8:0].
- Cycle N+1: held-key vector updated (set on press, clear on release). row_data reflects it at N+2, because row_data is registered: row_data <= ~row_vec(row_sel).
- row_sel change is visible on row_data 1 cycle later. row_sel 10–15 → 8'hFF.
- Mapping is combinational {ext,code} → {valid,row,col}. ext must match exactly. KP codes are ext=0 only; E0 70 (Insert) is unmapped.
  - r0 b0–7: KP0 70, KP1 69, KP2 72, KP3 7A, KP4 6B, KP5 73, KP6 74, KP7 6C
  - r1: b0 KP8 75, b1 KP9 7D, b2 KP* 7C, b3 KP+ 79, b4/b5 unmapped, b6 KP. 71, b7 RETURN (5A and E0 5A)
  - r2: @ 54, A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
  - r3: H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44
  - r4: P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D
  - r5: X 22, Y 35, Z 1A, [ 5B, ¥ 5D, ] 0E, ^ 55, - 4E
  - r6: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D
  - r7: 8 3E, 9 46, : 52, ; 4C, , 41, . 49, / 4A, _ 51
  - r8: b0 HOME E0 6C, b1 UP E0 75, b2 RIGHT E0 74, b3 INS/DEL (66 and E0 71), b4 GRPH 11, b5 KANA, b6 SHIFT (12, 59), b7 CTRL (14, E0 14)
  - r9: b0 STOP, b1–b5 F1 05, F2 06, F3 04, F4 0C, F5 03, b6 SPACE 29, b7 ESC 76
- Every physical source is its own held bit; a matrix bit is the OR of its sources. Releasing one of two keys sharing a bit (e.g. 12 and 59) keeps the bit asserted.
- Virtual keys:
  - LEFT E0 6B and DOWN E0 72 are held bits.
  - r8b2 = RIGHT | LEFT; r8b1 = UP | DOWN.
  - r8b6 = LSHIFT | RSHIFT | LEFT | DOWN.
- KANA: a press event on KANA_CODE toggles kana_lock; releases are ignored. r8b5 = kana_lock.
- Repeated press (typematic) of a held key: no change. Release of a key not held: no change. Unmapped code: ignored entirely, no state change.
- Simultaneous events are impossible (one ps2_key update per toggle). Back-to-back toggles on consecutive cycles must each be processed, with no drop.
- Reset: all held bits 0, kana_lock 0, row_data 8'hFF, key_any 0, tog_q <= ps2_key[10] so no spurious event is taken on release. Reset asserted mid-hold clears state; a later release of that key is a no-op.
- key_any is registered, same latency as row_data.

Test Plan:
- Reset, row_sel 0..15 → row_data 8'hFF on every row, key_any 0, kana_lock 0; no event on the first cycle after reset.
- Press A (ps2_key toggle, 9'h01C, pressed) with row_sel=2 → row_data 8'hFD exactly 2 cycles after the toggle. Release → 8'hFF.
- Press E0 6B (LEFT) → row8 = 8'hBB (b2, b6 low). Then press 12, release E0 6B → row8 = 8'hBF. Release 12 → 8'hFF.
- KANA press/release twice → kana_lock 1 then 0; row8 = 8'hDF after the first pair, 8'hFF after the second.
- Press 12 and 59, release 12 → row8 b6 still 0; release 59 → 8'hFF.
- Press Q, then E0 70 (unmapped) and 9'h070 (KP0) on consecutive cycles → row4 = 8'hFD, row0 = 8'hFE. Assert reset → all rows 8'hFF, and a later Q release changes nothing.

Source files
------------

// File: rtl/pc8001_ps2_keymatrix.sv
// PS/2 key events (hps_io ps2_key bus) to the PC-8001 10x8 keyboard matrix.
// Each physical key has its own held bit; matrix bits OR their sources and the row read is registered.
module pc8001_ps2_keymatrix #(
    parameter logic [8:0] KANA_CODE = 9'h013,
    parameter logic [8:0] STOP_CODE = 9'h001
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  row_sel,
    output logic [7:0]  row_data,
    output logic        kana_lock,
    output logic        key_any
);

    // Indices 0..79 are row*8+col of a key's primary source; 80+ are alternate
    // sources that share a matrix bit, plus the LEFT/DOWN virtual keys.
    localparam int NSRC      = 86;
    localparam int SRC_RET2  = 80;
    localparam int SRC_INS   = 81;
    localparam int SRC_RSH   = 82;
    localparam int SRC_RCTL  = 83;
    localparam int SRC_LEFT  = 84;
    localparam int SRC_DOWN  = 85;

    logic            tog_reg;
    logic [NSRC-1:0] held_reg;
    logic [NSRC-1:0] held_next;
    logic            key_ev;
    logic            is_kana;
    logic            src_valid;
    logic [6:0]      src_idx;
    logic [79:0]     mat;
    logic [7:0]      row_vec;

    // Returns {valid, source index}; ext bit must match exactly.
    function automatic logic [7:0] key_src(input logic [8:0] key);
        logic [7:0] r;
        r = 8'h00;
        if (key == STOP_CODE) begin
            r = {1'b1, 7'd72};
        end else begin
            case (key)
                9'h070: r = {1'b1, 7'd0};
                9'h069: r = {1'b1, 7'd1};
                9'h072: r = {1'b1, 7'd2};
                9'h07A: r = {1'b1, 7'd3};
                9'h06B: r = {1'b1, 7'd4};
                9'h073: r = {1'b1, 7'd5};
                9'h074: r = {1'b1, 7'd6};
                9'h06C: r = {1'b1, 7'd7};
                9'h075: r = {1'b1, 7'd8};
                9'h07D: r = {1'b1, 7'd9};
                9'h07C: r = {1'b1, 7'd10};
                9'h079: r = {1'b1, 7'd11};
                9'h071: r = {1'b1, 7'd14};
                9'h05A: r = {1'b1, 7'd15};
                9'h15A: r = {1'b1, 7'(SRC_RET2)};
                9'h054: r = {1'b1, 7'd16};
                9'h01C: r = {1'b1, 7'd17};
                9'h032: r = {1'b1, 7'd18};
                9'h021: r = {1'b1, 7'd19};
                9'h023: r = {1'b1, 7'd20};
                9'h024: r = {1'b1, 7'd21};
                9'h02B: r = {1'b1, 7'd22};
                9'h034: r = {1'b1, 7'd23};
                9'h033: r = {1'b1, 7'd24};
                9'h043: r = {1'b1, 7'd25};
                9'h03B: r = {1'b1, 7'd26};
                9'h042: r = {1'b1, 7'd27};
                9'h04B: r = {1'b1, 7'd28};
                9'h03A: r = {1'b1, 7'd29};
                9'h031: r = {1'b1, 7'd30};
                9'h044: r = {1'b1, 7'd31};
                9'h04D: r = {1'b1, 7'd32};
                9'h015: r = {1'b1, 7'd33};
                9'h02D: r = {1'b1, 7'd34};
                9'h01B: r = {1'b1, 7'd35};
                9'h02C: r = {1'b1, 7'd36};
                9'h03C: r = {1'b1, 7'd37};
                9'h02A: r = {1'b1, 7'd38};
                9'h01D: r = {1'b1, 7'd39};
                9'h022: r = {1'b1, 7'd40};
                9'h035: r = {1'b1, 7'd41};
                9'h01A: r = {1'b1, 7'd42};
                9'h05B: r = {1'b1, 7'd43};
                9'h05D: r = {1'b1, 7'd44};
                9'h00E: r = {1'b1, 7'd45};
                9'h055: r = {1'b1, 7'd46};
                9'h04E: r = {1'b1, 7'd47};
                9'h045: r = {1'b1, 7'd48};
                9'h016: r = {1'b1, 7'd49};
                9'h01E: r = {1'b1, 7'd50};
                9'h026: r = {1'b1, 7'd51};
                9'h025: r = {1'b1, 7'd52};
                9'h02E: r = {1'b1, 7'd53};
                9'h036: r = {1'b1, 7'd54};
                9'h03D: r = {1'b1, 7'd55};
                9'h03E: r = {1'b1, 7'd56};
                9'h046: r = {1'b1, 7'd57};
                9'h052: r = {1'b1, 7'd58};
                9'h04C: r = {1'b1, 7'd59};
                9'h041: r = {1'b1, 7'd60};
                9'h049: r = {1'b1, 7'd61};
                9'h04A: r = {1'b1, 7'd62};
                9'h051: r = {1'b1, 7'd63};
                9'h16C: r = {1'b1, 7'd64};
                9'h175: r = {1'b1, 7'd65};
                9'h174: r = {1'b1, 7'd66};
                9'h066: r = {1'b1, 7'd67};
                9'h171: r = {1'b1, 7'(SRC_INS)};
                9'h011: r = {1'b1, 7'd68};
                9'h012: r = {1'b1, 7'd70};
                9'h059: r = {1'b1, 7'(SRC_RSH)};
                9'h014: r = {1'b1, 7'd71};
                9'h114: r = {1'b1, 7'(SRC_RCTL)};
                9'h005: r = {1'b1, 7'd73};
                9'h006: r = {1'b1, 7'd74};
                9'h004: r = {1'b1, 7'd75};
                9'h00C: r = {1'b1, 7'd76};
                9'h003: r = {1'b1, 7'd77};
                9'h029: r = {1'b1, 7'd78};
                9'h076: r = {1'b1, 7'd79};
                9'h16B: r = {1'b1, 7'(SRC_LEFT)};
                9'h172: r = {1'b1, 7'(SRC_DOWN)};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        key_ev               = ps2_key[10] ^ tog_reg;
        is_kana              = (ps2_key[8:0] == KANA_CODE);
        {src_valid, src_idx} = key_src(ps2_key[8:0]);
        held_next            = held_reg;
        // Typematic repeats and releases of unheld keys rewrite the same value.
        if (key_ev && src_valid && !is_kana)
            held_next[src_idx] = ps2_key[9];
    end

    always_comb begin
        mat     = held_reg[79:0];
        mat[15] = held_reg[15] | held_reg[SRC_RET2];
        mat[65] = held_reg[65] | held_reg[SRC_DOWN];
        mat[66] = held_reg[66] | held_reg[SRC_LEFT];
        mat[67] = held_reg[67] | held_reg[SRC_INS];
        mat[69] = held_reg[69] | kana_lock;
        // Cursor LEFT/DOWN are RIGHT/UP with SHIFT on the PC-8001 matrix.
        mat[70] = held_reg[70] | held_reg[SRC_RSH] | held_reg[SRC_LEFT] | held_reg[SRC_DOWN];
        mat[71] = held_reg[71] | held_reg[SRC_RCTL];
        row_vec = 8'h00;
        for (int r = 0; r < 10; r++) begin
            if (row_sel == 4'(r))
                row_vec = mat[r*8 +: 8];
        end
    end

    always_ff @(posedge clk_sys) begin
        tog_reg <= ps2_key[10];
        if (reset) begin
            held_reg  <= '0;
            kana_lock <= 1'b0;
            row_data  <= 8'hFF;
            key_any   <= 1'b0;
        end else begin
            held_reg <= held_next;
            if (key_ev && is_kana && ps2_key[9])
                kana_lock <= ~kana_lock;
            row_data <= ~row_vec;
            key_any  <= (|held_reg) | kana_lock;
        end
    end

endmodule
